// File: rtl/axi_st_data_gen.sv
// axi_st_data_gen
// Streaming test-data generator for the card-to-host path. A rising edge on
// config_reg0[0] starts a run of fixed-length packets whose beats carry
// {packet index, beat index} in every 64-bit lane, so the host can check
// ordering and completeness. An optional idle gap separates packets.
//
// Ports
//   axi_clk, axi_rstn    clock, asynchronous active-low reset
//   config_reg0[0]       enable (rising edge starts a run, low ends it)
//   config_reg1          [15:0] beats per packet, [31:16] gap cycles
//   config_reg2          packets per run, 0 = continuous
//   m_axis_*             AXI4-Stream master (tdata/tkeep/tvalid/tready/tlast)
//   gen_busy             run in progress
//   gen_done             one-cycle pulse when a run ends
//   pkt_sent_cnt         packets completed in the current or last run
module axi_st_data_gen #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    axi_clk,
  input  logic                    axi_rstn,
  input  logic [31:0]             config_reg0,
  input  logic [31:0]             config_reg1,
  input  logic [31:0]             config_reg2,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    gen_busy,
  output logic                    gen_done,
  output logic [31:0]             pkt_sent_cnt
);

  localparam int LANES = DATA_WIDTH / 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        enPrev_q;
  logic        startPend_q, startPend_d;
  logic        stopReq_q, stopReq_d;
  logic        done_q, done_d;
  logic [15:0] beats_q, beats_d;
  logic [15:0] gapLen_q, gapLen_d;
  logic [15:0] gapCnt_q, gapCnt_d;
  logic [31:0] pktTarget_q, pktTarget_d;
  logic [31:0] pktCnt_q, pktCnt_d;
  logic [31:0] beatIdx_q, beatIdx_d;

  logic enable;
  logic startEdge;
  logic handshake;
  logic lastBeat;
  logic runEnd;

  assign enable    = config_reg0[0];
  assign startEdge = enable & ~enPrev_q;
  assign handshake = m_axis_tvalid & m_axis_tready;
  assign lastBeat  = (beatIdx_q == ({16'd0, beats_q} - 32'd1));

  // A run ends after the tlast beat either when the programmed packet count
  // is reached or when enable has been seen low at any point during the
  // packet; the packet itself is never truncated.
  assign runEnd = ((pktTarget_q != 32'd0) && ((pktCnt_q + 32'd1) == pktTarget_q))
                  || !enable || stopReq_q;

  // State and datapath registers.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q     <= IDLE;
      enPrev_q    <= 1'b0;
      startPend_q <= 1'b0;
      stopReq_q   <= 1'b0;
      done_q      <= 1'b0;
      beats_q     <= '0;
      gapLen_q    <= '0;
      gapCnt_q    <= '0;
      pktTarget_q <= '0;
      pktCnt_q    <= '0;
      beatIdx_q   <= '0;
    end else begin
      state_q     <= state_d;
      enPrev_q    <= enable;
      startPend_q <= startPend_d;
      stopReq_q   <= stopReq_d;
      done_q      <= done_d;
      beats_q     <= beats_d;
      gapLen_q    <= gapLen_d;
      gapCnt_q    <= gapCnt_d;
      pktTarget_q <= pktTarget_d;
      pktCnt_q    <= pktCnt_d;
      beatIdx_q   <= beatIdx_d;
    end
  end

  // Next-state logic. A start is latched on the edge it is detected and the
  // FSM leaves IDLE one edge later, so tvalid and gen_busy rise together one
  // cycle after the start edge.
  always_comb begin
    state_d     = state_q;
    startPend_d = 1'b0;
    stopReq_d   = stopReq_q;
    done_d      = 1'b0;
    beats_d     = beats_q;
    gapLen_d    = gapLen_q;
    gapCnt_d    = gapCnt_q;
    pktTarget_d = pktTarget_q;
    pktCnt_d    = pktCnt_q;
    beatIdx_d   = beatIdx_q;

    case (state_q)
      IDLE: begin
        if (startEdge) begin
          beats_d     = config_reg1[15:0];
          gapLen_d    = config_reg1[31:16];
          pktTarget_d = config_reg2;
          pktCnt_d    = '0;
          beatIdx_d   = '0;
          stopReq_d   = 1'b0;
          startPend_d = 1'b1;
        end
        // A zero-length packet configuration finishes immediately.
        if (startPend_q) begin
          if (beats_q == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end

      SEND: begin
        if (!enable) begin
          stopReq_d = 1'b1;
        end
        if (handshake) begin
          if (lastBeat) begin
            beatIdx_d = '0;
            pktCnt_d  = pktCnt_q + 32'd1;
            if (runEnd) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (gapLen_q != 16'd0) begin
              state_d  = GAP;
              gapCnt_d = gapLen_q;
            end
          end else begin
            beatIdx_d = beatIdx_q + 32'd1;
          end
        end
      end

      GAP: begin
        if (!enable) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gapCnt_q <= 16'd1) begin
          state_d = SEND;
        end else begin
          gapCnt_d = gapCnt_q - 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m_axis_tdata  = {LANES{pktCnt_q, beatIdx_q}};
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = (state_q == SEND) && lastBeat;
  assign gen_busy      = (state_q != IDLE);
  assign gen_done      = done_q;
  assign pkt_sent_cnt  = pktCnt_q;

endmodule
